// File: rtl/onehot_rr_arbiter_if.sv
// Handshake bundle between requesters and the round-robin arbiter.
//   req_i      : level request, one bit per requester
//   done_i     : release pulse from the current owner
//   gnt_o      : registered one-hot grant (zero when idle)
//   gnt_idx_o  : binary index of the granted requester (zero when idle)
//   gnt_vld_o  : a grant is active
//   timeout_o  : one-cycle pulse on a forced release (RR_ARB_TIMEOUT_EN builds only)
// Modports: master = requester side, slave = arbiter side.
interface onehot_rr_arbiter_if #(
  parameter int unsigned NUM_REQ = 8,
  parameter int unsigned IDX_W   = 3
);
  logic [NUM_REQ-1:0] req_i;
  logic               done_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic [IDX_W-1:0]   gnt_idx_o;
  logic               gnt_vld_o;
`ifdef RR_ARB_TIMEOUT_EN
  logic               timeout_o;

  modport master (
    output req_i, done_i,
    input  gnt_o, gnt_idx_o, gnt_vld_o, timeout_o
  );
  modport slave (
    input  req_i, done_i,
    output gnt_o, gnt_idx_o, gnt_vld_o, timeout_o
  );
`else
  modport master (
    output req_i, done_i,
    input  gnt_o, gnt_idx_o, gnt_vld_o
  );
  modport slave (
    input  req_i, done_i,
    output gnt_o, gnt_idx_o, gnt_vld_o
  );
`endif
endinterface

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with held grants. A winner is chosen in IDLE starting at the
// round-robin pointer, then the grant is frozen until the owner pulses done_i.
// Optional feature macro: RR_ARB_TIMEOUT_EN adds a hold-time limit of TIMEOUT_CYC
// cycles and the timeout_o pulse.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : onehot_rr_arbiter_if.slave (req_i, done_i in; gnt_o, gnt_idx_o,
//           gnt_vld_o, [timeout_o] out, all registered)
module onehot_rr_arbiter #(
  parameter int unsigned NUM_REQ     = 8,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  onehot_rr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               vld_q, vld_d;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   win_oh;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     ptr_nxt;
  int unsigned          win_off;
  int unsigned          winner;

  // Winner search: rotate the request vector so bit 0 is the pointer position, take
  // the lowest set bit, then map the offset back with an explicit modulo wrap.
  always_comb begin
    req_dbl = {bus.req_i, bus.req_i};
    req_rot = NUM_REQ'(req_dbl >> ptr_q);
    win_off = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) win_off = i;
    end
    winner = 32'(ptr_q) + win_off;
    if (winner >= NUM_REQ) winner = winner - NUM_REQ;

    win_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == i) win_oh[i] = 1'b1;
    end

    // OR-only one-hot encoder: each set bit contributes its own index.
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) win_idx = win_idx | IDX_W'(i);
    end

    ptr_nxt = (winner == NUM_REQ - 1) ? '0 : IDX_W'(winner + 1);
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned     CntW   = $clog2(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            to_q, to_d;
`else
  // No hold-time limit in this build; the parameter only keeps instantiations uniform.
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  logic release_grant;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    idx_d         = idx_q;
    vld_d         = vld_q;
    release_grant = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    to_d          = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (|bus.req_i) begin
          state_d = StBusy;
          gnt_d   = win_oh;
          idx_d   = win_idx;
          vld_d   = 1'b1;
          ptr_d   = ptr_nxt;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StBusy: begin
        release_grant = bus.done_i;
`ifdef RR_ARB_TIMEOUT_EN
        // A done_i in the limit cycle wins: normal release, no timeout pulse.
        if (!bus.done_i && (cnt_q == CntMax)) begin
          release_grant = 1'b1;
          to_d          = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        if (release_grant) begin
          state_d = StIdle;
          gnt_d   = '0;
          idx_d   = '0;
          vld_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign bus.timeout_o = to_q;
`endif

  assign bus.gnt_o     = gnt_q;
  assign bus.gnt_idx_o = idx_q;
  assign bus.gnt_vld_o = vld_q;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
`timescale 1ns/1ps
module tb_onehot_rr_arbiter;

  localparam int unsigned TimeoutCyc = 4;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  // Reference model state: who owns the resource, where the search starts next,
  // how long the current grant has been held, and whether the last edge timed out.
  typedef struct {
    bit busy;
    int owner;
    int ptr;
    int age;
    bit to;
  } mstate_t;

  logic    clk   = 1'b0;
  logic    rst_n = 1'b0;
  int      n_checks = 0;
  int      n_pass   = 0;
  mstate_t m8;
  mstate_t m5;

  always #5 clk = ~clk;

  onehot_rr_arbiter_if #(.NUM_REQ(8), .IDX_W(3)) bus8 ();
  onehot_rr_arbiter_if #(.NUM_REQ(5), .IDX_W(3)) bus5 ();

  onehot_rr_arbiter #(.NUM_REQ(8), .IDX_W(3), .TIMEOUT_CYC(TimeoutCyc)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  onehot_rr_arbiter #(.NUM_REQ(5), .IDX_W(3), .TIMEOUT_CYC(TimeoutCyc)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  function automatic mstate_t model_reset();
    mstate_t s;
    s.busy = 1'b0; s.owner = 0; s.ptr = 0; s.age = 0; s.to = 1'b0;
    return s;
  endfunction

  function automatic mstate_t model_next(mstate_t s, int n, logic [31:0] req, bit done);
    mstate_t r = s;
    r.to = 1'b0;
    if (!s.busy) begin
      for (int k = 0; k < n; k++) begin
        int c = (s.ptr + k) % n;
        if (req[c]) begin
          r.busy  = 1'b1;
          r.owner = c;
          r.ptr   = (c + 1) % n;
          r.age   = 0;
          break;
        end
      end
    end else if (done) begin
      r.busy = 1'b0;
    end else if (ToEn && s.age == int'(TimeoutCyc) - 1) begin
      r.busy = 1'b0;
      r.to   = 1'b1;
    end else begin
      r.age = s.age + 1;
    end
    return r;
  endfunction

  // {timeout, vld, idx, gnt}
  function automatic logic [12:0] exp8(mstate_t s);
    logic [7:0] g  = s.busy ? 8'(1 << s.owner) : 8'h00;
    logic [2:0] ix = s.busy ? 3'(s.owner) : 3'd0;
    return {s.to, s.busy, ix, g};
  endfunction

  function automatic logic [12:0] act8();
    logic t = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    t = bus8.timeout_o;
`endif
    return {t, bus8.gnt_vld_o, bus8.gnt_idx_o, bus8.gnt_o};
  endfunction

  // {vld, idx, gnt}
  function automatic logic [8:0] exp5(mstate_t s);
    logic [4:0] g  = s.busy ? 5'(1 << s.owner) : 5'h00;
    logic [2:0] ix = s.busy ? 3'(s.owner) : 3'd0;
    return {s.busy, ix, g};
  endfunction

  function automatic logic [8:0] act5();
    return {bus5.gnt_vld_o, bus5.gnt_idx_o, bus5.gnt_o};
  endfunction

  task automatic tick(input logic [7:0] req, input bit done);
    bus8.req_i  = req;
    bus8.done_i = done;
    @(posedge clk);
    m8 = model_next(m8, 8, 32'(req), done);
    m5 = model_next(m5, 5, 32'(bus5.req_i), bus5.done_i);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m8 = model_reset();
    m5 = model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (act8() !== 13'h0) $display("FAIL reset_initial: got %h want 0", act8());
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick(8'h10, 1'b0);
    n_checks++;
    if (bus8.gnt_o !== 8'h10 || bus8.gnt_idx_o !== 3'd4 || bus8.gnt_vld_o !== 1'b1)
      $display("FAIL reset_first_grant: got gnt %h idx %0d vld %b want 10/4/1",
               bus8.gnt_o, bus8.gnt_idx_o, bus8.gnt_vld_o);
    else n_pass++;
    tick(8'h00, 1'b0);
    // Asynchronous reset in the middle of a busy cycle.
    #2;
    rst_n = 1'b0;
    m8 = model_reset();
    m5 = model_reset();
    #1;
    n_checks++;
    if (act8() !== 13'h0) $display("FAIL reset_mid_busy: got %h want 0", act8());
    else n_pass++;
    #1;
    rst_n = 1'b1;
    tick(8'h01, 1'b0);
    n_checks++;
    if (bus8.gnt_o !== 8'h01 || bus8.gnt_idx_o !== 3'd0 || bus8.gnt_vld_o !== 1'b1)
      $display("FAIL reset_after_release: got gnt %h idx %0d want 01/0",
               bus8.gnt_o, bus8.gnt_idx_o);
    else n_pass++;
    tick(8'h00, 1'b1);
    n_checks++;
    if (act8() !== exp8(m8)) $display("FAIL reset_release: got %h want %h", act8(), exp8(m8));
    else n_pass++;
  endtask

  task automatic test_rotation();
    int k = 0;
    apply_reset();
    for (int c = 0; c < 17; c++) begin
      tick(8'hFF, 1'b1);
      n_checks++;
      if (act8() !== exp8(m8))
        $display("FAIL rotation_cycle %0d: got %h want %h", c, act8(), exp8(m8));
      else n_pass++;
      if (m8.busy) begin
        n_checks++;
        if (bus8.gnt_idx_o !== 3'(k % 8))
          $display("FAIL rotation_index %0d: got %0d want %0d", k, bus8.gnt_idx_o, k % 8);
        else n_pass++;
        k++;
      end
    end
  endtask

  task automatic test_skip_wrap();
    apply_reset();
    tick(8'h20, 1'b0);
    tick(8'h00, 1'b1);
    tick(8'h05, 1'b0);
    n_checks++;
    if (bus8.gnt_idx_o !== 3'd0 || bus8.gnt_o !== 8'h01)
      $display("FAIL skip_wrap_first: got idx %0d gnt %h want 0/01", bus8.gnt_idx_o, bus8.gnt_o);
    else n_pass++;
    tick(8'h00, 1'b1);
    tick(8'h05, 1'b0);
    n_checks++;
    if (bus8.gnt_idx_o !== 3'd2 || bus8.gnt_o !== 8'h04)
      $display("FAIL skip_wrap_second: got idx %0d gnt %h want 2/04", bus8.gnt_idx_o, bus8.gnt_o);
    else n_pass++;
    n_checks++;
    if (act8() !== exp8(m8)) $display("FAIL skip_wrap_model: got %h want %h", act8(), exp8(m8));
    else n_pass++;
  endtask

  task automatic test_hold();
    int hold_cyc = ToEn ? int'(TimeoutCyc) - 2 : 10;
    apply_reset();
    tick(8'h08, 1'b0);
    for (int c = 0; c < hold_cyc; c++) begin
      tick(8'h80, 1'b0);
      n_checks++;
      if (bus8.gnt_o !== 8'h08 || bus8.gnt_vld_o !== 1'b1)
        $display("FAIL hold_cycle %0d: got gnt %h vld %b want 08/1", c, bus8.gnt_o,
                 bus8.gnt_vld_o);
      else n_pass++;
    end
    tick(8'h80, 1'b1);
    n_checks++;
    if (bus8.gnt_vld_o !== 1'b0 || bus8.gnt_o !== 8'h00)
      $display("FAIL hold_release: got gnt %h vld %b want 00/0", bus8.gnt_o, bus8.gnt_vld_o);
    else n_pass++;
    tick(8'h80, 1'b0);
    n_checks++;
    if (bus8.gnt_o !== 8'h80 || bus8.gnt_idx_o !== 3'd7)
      $display("FAIL hold_next_grant: got gnt %h idx %0d want 80/7", bus8.gnt_o, bus8.gnt_idx_o);
    else n_pass++;
  endtask

`ifdef RR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    tick(8'h02, 1'b0);
    for (int c = 1; c < int'(TimeoutCyc); c++) begin
      tick(8'h00, 1'b0);
      n_checks++;
      if (bus8.gnt_vld_o !== 1'b1 || bus8.timeout_o !== 1'b0)
        $display("FAIL timeout_hold %0d: got vld %b to %b want 1/0", c, bus8.gnt_vld_o,
                 bus8.timeout_o);
      else n_pass++;
    end
    tick(8'h03, 1'b0);
    n_checks++;
    if (bus8.gnt_vld_o !== 1'b0 || bus8.timeout_o !== 1'b1)
      $display("FAIL timeout_fire: got vld %b to %b want 0/1", bus8.gnt_vld_o, bus8.timeout_o);
    else n_pass++;
    // Offender 1 is behind the pointer now, so requester 0 is served first.
    tick(8'h03, 1'b0);
    n_checks++;
    if (bus8.timeout_o !== 1'b0 || bus8.gnt_idx_o !== 3'd0 || bus8.gnt_vld_o !== 1'b1)
      $display("FAIL timeout_after: got to %b idx %0d vld %b want 0/0/1", bus8.timeout_o,
               bus8.gnt_idx_o, bus8.gnt_vld_o);
    else n_pass++;
    for (int c = 1; c < int'(TimeoutCyc); c++) tick(8'h00, 1'b0);
    tick(8'h00, 1'b1);
    n_checks++;
    if (bus8.gnt_vld_o !== 1'b0 || bus8.timeout_o !== 1'b0)
      $display("FAIL timeout_done_wins: got vld %b to %b want 0/0", bus8.gnt_vld_o,
               bus8.timeout_o);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic [7:0] req;
    bit         done;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      req  = 8'($urandom);
      if ($urandom_range(0, 5) == 0) req = 8'h00;
      done = ($urandom_range(0, 2) == 0);
      tick(req, done);
      n_checks++;
      if (act8() !== exp8(m8))
        $display("FAIL random_cycle %0d: req %h done %b got %h want %h", c, req, done, act8(),
                 exp8(m8));
      else n_pass++;
    end
  endtask

  task automatic test_npot();
    int g = 0;
    apply_reset();
    bus5.req_i  = 5'h11;
    bus5.done_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick(8'h00, 1'b0);
      n_checks++;
      if (act5() !== exp5(m5))
        $display("FAIL npot_cycle %0d: got %h want %h", c, act5(), exp5(m5));
      else n_pass++;
      n_checks++;
      if (u_dut5.ptr_q > 3'd4) $display("FAIL npot_ptr %0d: got %0d want <=4", c, u_dut5.ptr_q);
      else n_pass++;
      if (m5.busy) begin
        n_checks++;
        if (bus5.gnt_idx_o !== ((g % 2 == 0) ? 3'd0 : 3'd4))
          $display("FAIL npot_alternate %0d: got %0d want %0d", g, bus5.gnt_idx_o,
                   (g % 2 == 0) ? 0 : 4);
        else n_pass++;
        g++;
      end
    end
    bus5.req_i  = '0;
    bus5.done_i = 1'b0;
  endtask

  initial begin
    bus8.req_i  = '0;
    bus8.done_i = 1'b0;
    bus5.req_i  = '0;
    bus5.done_i = 1'b0;
    m8 = model_reset();
    m5 = model_reset();
    test_reset();
    test_rotation();
    test_skip_wrap();
    test_hold();
`ifdef RR_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    test_npot();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/onehot_rr_arbiter.md
# onehot_rr_arbiter

Round-robin arbiter that shares one downstream resource among `NUM_REQ` requesters. It produces a registered one-hot grant and the matching binary grant index, encoded by the team's OR-only one-hot encoder. Each grant is held until the owning requester signals release, so a requester owns the resource for a whole multi-cycle transaction. It sits in front of any shared port: a bus master mux, a shared FIFO write port or a DMA channel.

## Interface
- `NUM_REQ`, default 8: number of requesters, 2..32.
- `IDX_W`, default 3: grant index width. Must satisfy 2**IDX_W >= NUM_REQ.
- `TIMEOUT_CYC`, default 256: maximum cycles a grant is held. Used only when `RR_ARB_TIMEOUT_EN` is defined; must be >= 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_i` in NUM_REQ: level request, one bit per requester.
- `done_i` in 1: release pulse from the current owner; meaningful only while `gnt_vld_o` = 1.
- `gnt_o` out NUM_REQ: registered one-hot grant; all zeros when idle.
- `gnt_idx_o` out IDX_W: binary index of the `gnt_o` bit; 0 when idle.
- `gnt_vld_o` out 1: a grant is active.
- `timeout_o` out 1: one-cycle pulse on a forced release. This port exists only when `RR_ARB_TIMEOUT_EN` is defined.

## Operation
- Two-state FSM: IDLE and BUSY. Round-robin pointer `ptr` (IDX_W bits) names the highest-priority requester.
- **IDLE:**
  - If `req_i` != 0, select the first set bit at or after `ptr`, searching upward and wrapping past NUM_REQ-1 to 0.
  - Register the selection into `gnt_o`. Set `gnt_vld_o` = 1 and go to BUSY.
  - Update `ptr` = (winner + 1) mod NUM_REQ. The wrap is explicit; for non-power-of-two NUM_REQ, `ptr` never holds values >= NUM_REQ.
  - If `req_i` == 0, stay in IDLE with outputs zero and `ptr` unchanged.
- **BUSY:**
  - The grant is frozen; `req_i` is ignored, including withdrawal of the owner's own request.
  - `done_i` = 1: next cycle clear `gnt_o`, `gnt_idx_o` and `gnt_vld_o` and return to IDLE.
- `gnt_idx_o` is the onehot-encode of the next `gnt_o` and is registered in the same flop stage as `gnt_o`, so the two are always consistent.
- **Simultaneous requests:** the requester nearest at or after `ptr` wins. No requester waits more than NUM_REQ-1 grants.
- **Reset, including mid-grant:** asynchronously force IDLE, `ptr` = 0, `gnt_o` = 0, `gnt_idx_o` = 0, `gnt_vld_o` = 0, `timeout_o` = 0. Any transaction in progress is dropped without a release.

## Timing
- Arbitration latency: 1 cycle. `req_i` sampled at edge N in IDLE gives `gnt_vld_o` high after edge N.
- Release: `done_i` sampled high at edge M in BUSY gives `gnt_vld_o` low after edge M.
- Minimum one idle cycle between consecutive grants. Peak utilisation is therefore (L)/(L+1) for hold length L.
- `done_i` in IDLE is ignored.
- `done_i` together with a timeout in the same cycle is treated as a normal release, with no `timeout_o` pulse.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `RR_ARB_TIMEOUT_EN` defined:
  - A cycle counter of width clog2(TIMEOUT_CYC) clears on entry to BUSY and increments each BUSY cycle.
  - If the counter reaches TIMEOUT_CYC-1 with `done_i` low, the grant is force-released on that edge exactly as if `done_i` were high, and `timeout_o` pulses for one cycle coincident with `gnt_vld_o` falling.
  - `ptr` is already past the offender, so the offender is next served only after the other requesters.
- `RR_ARB_TIMEOUT_EN` undefined: no counter and no `timeout_o` port. A grant is held indefinitely until `done_i`.

## Test plan
- **Reset and idle:** assert `rst_n`=0 mid-BUSY with `gnt_o`=8'h10 -> all outputs 0 immediately. After release, `req_i`=8'h01 -> `gnt_o`=8'h01, `gnt_idx_o`=0 one cycle later.
- **Rotation:** `req_i`=8'hFF held, `done_i` pulsed each BUSY cycle -> grant indices 0,1,2,…,7,0 with one idle cycle between grants.
- **Priority skip and wrap:**
  - `ptr`=6, `req_i`=8'h05 -> grant index 0, `ptr` becomes 1.
  - Then `req_i`=8'h05 -> grant index 2.
- **Grant hold:** grant to requester 3, then `req_i` changes to 8'h80 for 10 cycles without `done_i` -> `gnt_o` stays 8'h08. After `done_i` -> idle 1 cycle, then `gnt_o`=8'h80.
- **Non-power-of-two:** NUM_REQ=5, IDX_W=3, `req_i`=5'h11 repeated -> grants alternate index 4 and index 0, and `ptr` never exceeds 4.
- **Timeout (macro on, TIMEOUT_CYC=4):** grant held without `done_i` -> `gnt_vld_o` falls and `timeout_o` pulses exactly 4 cycles after the grant. With `done_i` in the 4th cycle, there is no `timeout_o` pulse.
